// File: rtl/matmul_tile_sequencer.sv
// Walks a rows x N matrix-vector job through the 4-lane INT8 matmul accelerator one 4-row tile at a time.
// Optional macro MATMUL_SEQ_RELU_EN clamps negative row results to zero before they are emitted.
module matmul_tile_sequencer #(
   parameter logic [31:0] ACCEL_BASE   = 32'h8000_0000,
   parameter int unsigned MAX_N        = 1024,
   parameter int unsigned POLL_TIMEOUT = 4096
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        job_valid,
   output logic        job_ready,
   input  logic [31:0] job_w_base,
   input  logic [31:0] job_x_base,
   input  logic [15:0] job_rows,
   input  logic [31:0] job_n_dim,
   output logic        job_done,
   output logic        job_err,
   output logic        busy,
   output logic [31:0] acc_addr,
   output logic [31:0] acc_wdata,
   output logic [3:0]  acc_we,
   output logic        acc_re,
   input  logic [31:0] acc_rdata,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [31:0] res_data,
   output logic [15:0] res_row,
   output logic        res_last
);

   localparam int          PT_W    = $clog2(POLL_TIMEOUT + 1);
   localparam logic [31:0] MAX_N_W = 32'(MAX_N);

   typedef enum logic [3:0] {
      S_IDLE, S_CHECK, S_WR_W, S_WR_X, S_WR_M, S_WR_N, S_WR_GO,
      S_POLL_RD, S_POLL_CHK, S_RES_RD, S_RES_CAP, S_RES_PUSH, S_NEXT, S_ACK
   } state_t;

   state_t             state, state_nxt;
   logic [31:0]        w_ptr, desc_x, desc_n;
   logic [15:0]        desc_rows, row_base, rem;
   logic [2:0]         lane, tile_m;
   logic [PT_W-1:0]    poll_cnt;
   logic signed [31:0] res_data_q;
   logic [15:0]        row_idx;
   logic               desc_bad, poll_expired;

   function automatic logic signed [31:0] cap_result(input logic signed [31:0] v);
`ifdef MATMUL_SEQ_RELU_EN
      return (v < 0) ? 32'sd0 : v;
`else
      return v;
`endif
   endfunction

   assign tile_m       = (rem >= 16'd4) ? 3'd4 : rem[2:0];
   assign row_idx      = row_base + {13'd0, lane};
   assign desc_bad     = (desc_rows == 16'd0) || (desc_n == 32'd0) ||
                         (desc_n[1:0] != 2'b00) || (desc_n > MAX_N_W);
   assign poll_expired = (poll_cnt == PT_W'(POLL_TIMEOUT - 1));

   assign busy      = (state != S_IDLE);
   assign res_data  = res_valid ? res_data_q : 32'd0;
   assign res_row   = res_valid ? row_idx : 16'd0;
   assign res_last  = res_valid && (row_idx == desc_rows - 16'd1);

   always_comb begin
      state_nxt = state;
      job_ready = 1'b0;
      job_done  = 1'b0;
      job_err   = 1'b0;
      acc_addr  = 32'd0;
      acc_wdata = 32'd0;
      acc_we    = 4'h0;
      acc_re    = 1'b0;
      res_valid = 1'b0;
      case (state)
         S_IDLE: begin
            job_ready = 1'b1;
            if (job_valid) state_nxt = S_CHECK;
         end
         S_CHECK: begin
            if (desc_bad) begin
               job_done  = 1'b1;
               job_err   = 1'b1;
               state_nxt = S_IDLE;
            end else begin
               state_nxt = S_WR_W;
            end
         end
         S_WR_W: begin
            acc_addr = ACCEL_BASE + 32'h04; acc_wdata = w_ptr; acc_we = 4'hF;
            state_nxt = S_WR_X;
         end
         S_WR_X: begin
            acc_addr = ACCEL_BASE + 32'h08; acc_wdata = desc_x; acc_we = 4'hF;
            state_nxt = S_WR_M;
         end
         S_WR_M: begin
            acc_addr = ACCEL_BASE + 32'h0C; acc_wdata = {29'd0, tile_m}; acc_we = 4'hF;
            state_nxt = S_WR_N;
         end
         S_WR_N: begin
            acc_addr = ACCEL_BASE + 32'h10; acc_wdata = desc_n; acc_we = 4'hF;
            state_nxt = S_WR_GO;
         end
         S_WR_GO: begin
            acc_addr = ACCEL_BASE; acc_wdata = 32'h1; acc_we = 4'hF;
            state_nxt = S_POLL_RD;
         end
         // An expired poll window aborts without touching the accelerator again
         S_POLL_RD: begin
            if (poll_expired) begin
               job_done  = 1'b1;
               job_err   = 1'b1;
               state_nxt = S_IDLE;
            end else begin
               acc_addr  = ACCEL_BASE;
               acc_re    = 1'b1;
               state_nxt = S_POLL_CHK;
            end
         end
         S_POLL_CHK: begin
            if (acc_rdata[1]) begin
               state_nxt = S_RES_RD;
            end else if (poll_expired) begin
               job_done  = 1'b1;
               job_err   = 1'b1;
               state_nxt = S_IDLE;
            end else begin
               state_nxt = S_POLL_RD;
            end
         end
         S_RES_RD: begin
            acc_addr  = ACCEL_BASE + 32'h14 + {27'd0, lane, 2'b00};
            acc_re    = 1'b1;
            state_nxt = S_RES_CAP;
         end
         S_RES_CAP: state_nxt = S_RES_PUSH;
         S_RES_PUSH: begin
            res_valid = 1'b1;
            if (res_ready) state_nxt = (lane + 3'd1 == tile_m) ? S_NEXT : S_RES_RD;
         end
         S_NEXT: state_nxt = (rem - {13'd0, tile_m} != 16'd0) ? S_WR_W : S_ACK;
         S_ACK: begin
            acc_addr  = ACCEL_BASE; acc_wdata = 32'h0; acc_we = 4'hF;
            job_done  = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_IDLE;
         w_ptr    <= 32'd0;
         row_base <= 16'd0;
         rem      <= 16'd0;
         lane     <= 3'd0;
         poll_cnt <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            S_IDLE: if (job_valid) begin
               w_ptr    <= job_w_base;
               row_base <= 16'd0;
               rem      <= job_rows;
            end
            S_WR_GO: begin
               poll_cnt <= '0;
               lane     <= 3'd0;
            end
            S_POLL_RD, S_POLL_CHK: poll_cnt <= poll_cnt + PT_W'(1);
            S_RES_PUSH: if (res_ready) lane <= lane + 3'd1;
            S_NEXT: begin
               w_ptr    <= w_ptr + (desc_n << 2);
               row_base <= row_base + 16'd4;
               rem      <= rem - {13'd0, tile_m};
               lane     <= 3'd0;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (state == S_IDLE && job_valid) begin
         desc_x    <= job_x_base;
         desc_rows <= job_rows;
         desc_n    <= job_n_dim;
      end
      if (state == S_RES_CAP) res_data_q <= cap_result(acc_rdata);
   end

endmodule

// File: tb/tb_matmul_tile_sequencer.sv
// Scoreboard bench for matmul_tile_sequencer with a behavioural accelerator MMIO model.
module tb_matmul_tile_sequencer;
   localparam logic [31:0] BASE = 32'h8000_0000;
   localparam int          PTO  = 16;

   logic        clk = 1'b0, reset = 1'b1;
   logic        job_valid = 1'b0, job_ready, job_done, job_err, busy;
   logic [31:0] job_w_base = '0, job_x_base = '0, job_n_dim = '0;
   logic [15:0] job_rows = '0;
   logic [31:0] acc_addr, acc_wdata, acc_rdata = '0;
   logic [3:0]  acc_we;
   logic        acc_re, res_valid, res_ready = 1'b1, res_last;
   logic [31:0] res_data;
   logic [15:0] res_row;

   matmul_tile_sequencer #(.ACCEL_BASE(BASE), .MAX_N(1024), .POLL_TIMEOUT(PTO)) dut (
      .clk(clk), .reset(reset), .job_valid(job_valid), .job_ready(job_ready),
      .job_w_base(job_w_base), .job_x_base(job_x_base), .job_rows(job_rows),
      .job_n_dim(job_n_dim), .job_done(job_done), .job_err(job_err), .busy(busy),
      .acc_addr(acc_addr), .acc_wdata(acc_wdata), .acc_we(acc_we), .acc_re(acc_re),
      .acc_rdata(acc_rdata), .res_valid(res_valid), .res_ready(res_ready),
      .res_data(res_data), .res_row(res_row), .res_last(res_last)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0, passes = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic fail_now(input string name, input logic [31:0] act);
      checks++;
      $display("FAIL %s: got %h expected nothing (cycle %0d)", name, act, cyc);
   endtask

   // Accelerator model: status reports done on the done_after-th poll since GO
   logic [31:0] m_w = '0, m_n = 32'd4, cur_w_base = '0;
   logic [31:0] res_tab [0:7];
   int          polls = 0, done_after = 3;
   bit          never_done = 1'b0;

   always @(posedge clk) begin
      if (acc_we == 4'hF) begin
         if (acc_addr == BASE + 32'h04) m_w <= acc_wdata;
         if (acc_addr == BASE + 32'h10) m_n <= acc_wdata;
         if (acc_addr == BASE)          polls <= 0;
      end
      if (acc_re) begin
         if (acc_addr == BASE) begin
            polls     <= polls + 1;
            acc_rdata <= {30'd0, (!never_done && (polls + 1 >= done_after)), 1'b0};
         end else begin
            acc_rdata <= res_tab[((m_w - cur_w_base) / (m_n << 2)) * 4 + (acc_addr - BASE - 32'h14) / 4];
         end
      end
   end

   typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
   typedef struct { logic [31:0] data; logic [15:0] row; logic last; } res_t;
   typedef struct { logic err; int at; } done_t;
   wr_t   exp_wr[$];
   res_t  exp_res[$];
   done_t exp_done[$];

   int          first_we = -1, first_re = -1, act_cnt = 0;
   bit          done_seen = 1'b0;
   int          stall_row = -1, stall_left = 0;
   bit          st_armed = 1'b0;
   logic [31:0] st_data;
   logic [15:0] st_row;

   always @(negedge clk) begin
      if (!reset) begin
         if (acc_we != 4'h0 || acc_re) begin
            act_cnt++;
            chk("we_re_exclusive", {31'd0, acc_we != 4'h0 && acc_re}, 32'd0);
         end
         if (acc_re && first_re < 0) first_re = cyc;
         if (acc_we != 4'h0) begin
            wr_t w;
            if (first_we < 0) first_we = cyc;
            if (exp_wr.size() == 0) fail_now("unexpected_write", acc_addr);
            else begin
               w = exp_wr.pop_front();
               chk("wr_addr", acc_addr, w.addr);
               chk("wr_data", acc_wdata, w.data);
               chk("wr_be", {28'd0, acc_we}, 32'hF);
            end
         end
         // res_ready decided before sampling the handshake for the coming edge
         if (res_valid && stall_left > 0 && res_row == stall_row[15:0]) begin
            if (!st_armed) begin
               st_data  = res_data;
               st_row   = res_row;
               st_armed = 1'b1;
            end else begin
               chk("stall_data", res_data, st_data);
               chk("stall_row", {16'd0, res_row}, {16'd0, st_row});
            end
            chk("stall_valid", {31'd0, res_valid}, 32'd1);
            chk("stall_no_re", {31'd0, acc_re}, 32'd0);
            res_ready = 1'b0;
            stall_left--;
         end else begin
            res_ready = 1'b1;
         end
         if (res_valid && res_ready) begin
            res_t r;
            if (exp_res.size() == 0) fail_now("unexpected_result", res_data);
            else begin
               r = exp_res.pop_front();
               chk("res_data", res_data, r.data);
               chk("res_row", {16'd0, res_row}, {16'd0, r.row});
               chk("res_last", {31'd0, res_last}, {31'd0, r.last});
            end
         end
         if (job_err && !job_done) fail_now("err_without_done", 32'd1);
         if (job_done) begin
            done_t d;
            done_seen = 1'b1;
            if (exp_done.size() == 0) fail_now("unexpected_done", 32'd1);
            else begin
               d = exp_done.pop_front();
               chk("job_err", {31'd0, job_err}, {31'd0, d.err});
               if (d.at >= 0) chk("done_cycle", cyc, d.at);
            end
         end
      end
   end

   function automatic logic [31:0] emitted(input logic [31:0] v);
`ifdef MATMUL_SEQ_RELU_EN
      return ($signed(v) < 0) ? 32'd0 : v;
`else
      return v;
`endif
   endfunction

   task automatic run_job(input logic [31:0] w, input logic [31:0] x, input logic [15:0] rows,
                          input logic [31:0] n, input bit valid, input bit tmo, input bit timing);
      int T, rem;
      @(negedge clk);
      #1;
      chk("job_ready_idle", {31'd0, job_ready}, 32'd1);
      cur_w_base = w;
      job_w_base = w; job_x_base = x; job_rows = rows; job_n_dim = n; job_valid = 1'b1;
      T = cyc;
      first_we = -1; first_re = -1; act_cnt = 0; done_seen = 1'b0;
      if (!valid) begin
         exp_done.push_back('{1'b1, T + 1});
      end else begin
         rem = int'(rows);
         for (int t = 0; rem > 0; t++) begin
            int m;
            m = (rem > 4) ? 4 : rem;
            exp_wr.push_back('{BASE + 32'h04, w + 32'(t) * (n << 2)});
            exp_wr.push_back('{BASE + 32'h08, x});
            exp_wr.push_back('{BASE + 32'h0C, 32'(m)});
            exp_wr.push_back('{BASE + 32'h10, n});
            exp_wr.push_back('{BASE, 32'h1});
            if (tmo) break;
            for (int l = 0; l < m; l++)
               exp_res.push_back('{emitted(res_tab[t*4+l]), 16'(t*4+l), (t*4+l == int'(rows) - 1)});
            rem -= m;
         end
         if (!tmo) exp_wr.push_back('{BASE, 32'h0});
         exp_done.push_back('{tmo, -1});
      end
      @(posedge clk);
      #1 job_valid = 1'b0;
      for (int i = 0; i < 2000 && !done_seen; i++) begin
         @(negedge clk);
         #1;
      end
      if (!done_seen) fail_now("done_timeout", 32'd0);
      if (!valid) chk("invalid_no_mmio", act_cnt, 32'd0);
      if (timing) begin
         chk("first_write_cycle", first_we, T + 2);
         chk("first_poll_cycle", first_re, T + 7);
      end
      chk("wr_queue_drained", exp_wr.size(), 32'd0);
      chk("res_queue_drained", exp_res.size(), 32'd0);
      exp_wr.delete(); exp_res.delete(); exp_done.delete();
      repeat (3) @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < 8; i++) res_tab[i] = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_job_ready", {31'd0, job_ready}, 32'd1);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_acc_we", {28'd0, acc_we}, 32'd0);
      chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
      @(negedge clk) reset = 1'b0;
      #1;
      chk("idle_job_ready", {31'd0, job_ready}, 32'd1);
      chk("idle_acc_re", {31'd0, acc_re}, 32'd0);
      chk("idle_job_done", {31'd0, job_done}, 32'd0);

      // Single tile: results {10,-3,0,7}, done on the third poll
      res_tab[0] = 32'd10; res_tab[1] = 32'hFFFF_FFFD; res_tab[2] = 32'd0; res_tab[3] = 32'd7;
      run_job(32'h0000_2000, 32'h0000_3000, 16'd4, 32'd8, 1'b1, 1'b0, 1'b1);

      // Two tiles with a five-cycle stall on row 1
      res_tab[0] = 32'd1; res_tab[1] = 32'd2; res_tab[2] = 32'd3; res_tab[3] = 32'd4;
      res_tab[4] = 32'hFFFF_FFFB; res_tab[5] = 32'd6;
      stall_row = 1; stall_left = 5; st_armed = 1'b0;
      run_job(32'h0000_1000, 32'h0000_4000, 16'd6, 32'd16, 1'b1, 1'b0, 1'b0);
      chk("stall_consumed", stall_left, 32'd0);

      // Malformed descriptors
      run_job(32'h0000_1000, 32'h0000_4000, 16'd4, 32'd6, 1'b0, 1'b0, 1'b0);
      run_job(32'h0000_1000, 32'h0000_4000, 16'd4, 32'd2048, 1'b0, 1'b0, 1'b0);
      run_job(32'h0000_1000, 32'h0000_4000, 16'd0, 32'd8, 1'b0, 1'b0, 1'b0);

      // Accelerator never finishes, then a normal job follows
      never_done = 1'b1;
      run_job(32'h0000_5000, 32'h0000_6000, 16'd4, 32'd8, 1'b1, 1'b1, 1'b0);
      never_done = 1'b0;
      res_tab[0] = 32'd100; res_tab[1] = 32'h8000_0000; res_tab[2] = 32'd5; res_tab[3] = 32'hFFFF_FFFF;
      run_job(32'hFFFF_FFE0, 32'h0000_7000, 16'd3, 32'd4, 1'b1, 1'b0, 1'b1);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passes, checks);
      $fatal(1);
   end

endmodule
